// File: rtl/int_add_wb_stage.sv
// -----------------------------------------------------------------------------
// int_add_wb_stage
//
// Writeback stage behind the integer adder. A destination tag follows each
// accepted add/sub/addi uop through the adder latency. When the tag leaves the
// last pipe stage, add_value is captured alongside it and the {rd, data} pair
// is queued. Results whose destination is x0 are dropped silently. The queue
// drains to the register-file write port through a valid/ready handshake.
// issue_stall is a credit check: queued results plus in-flight tags must never
// exceed the queue depth.
//
// Parameters:
//   DATA_WIDTH   result width (defaults to `DATA_WIDTH, or 32 if not defined)
//   DEPTH        result FIFO entries; power of two, >= 2
//   ADD_LATENCY  clock edges from issue to a stable add_value; >= 1
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   uop_valid_in  adder uop issued this cycle
//   uop_rd        destination register of the issued uop
//   add_value     adder result
//   issue_stall   upstream must not issue
//   wb_valid      FIFO head valid
//   wb_ready      register file accepts the head
//   wb_rd         head destination register
//   wb_data       head result
//   wb_count      FIFO occupancy, 0..DEPTH
//   drop_err      sticky: a uop was presented while stalled
//
// Optional feature, macro INT_WB_FWD_EN:
//   fwd_valid / fwd_rd / fwd_data carry the most recently captured non-x0
//   result for one cycle after its capture edge, for operand bypass.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module int_add_wb_stage #(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int DEPTH       = 4,
  parameter int ADD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uop_valid_in,
  input  logic [4:0]              uop_rd,
  input  logic [DATA_WIDTH-1:0]   add_value,
  output logic                    issue_stall,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [4:0]              wb_rd,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic [$clog2(DEPTH):0]  wb_count,
`ifdef INT_WB_FWD_EN
  output logic                    fwd_valid,
  output logic [4:0]              fwd_rd,
  output logic [DATA_WIDTH-1:0]   fwd_data,
`endif
  output logic                    drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Tag pipe: stage 0 is loaded on the accept edge, the last stage is the
  // one whose tag is paired with add_value.
  logic [ADD_LATENCY-1:0] pipe_valid;
  logic [4:0]             pipe_rd [ADD_LATENCY];

  // Result FIFO storage.
  logic [4:0]             mem_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]  mem_data [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  logic       accept;
  logic       push;
  logic       pop;
  logic [4:0] cap_rd;
  int         inflight;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < ADD_LATENCY; i++) begin
      inflight = inflight + int'(pipe_valid[i]);
    end
  end

  // Credit check from registered state only: no path from wb_ready or
  // uop_valid_in, so a pop frees a credit one cycle later.
  assign issue_stall = (int'(wb_count) + inflight) >= DEPTH;
  assign accept      = uop_valid_in & ~issue_stall;

  assign cap_rd   = pipe_rd[ADD_LATENCY-1];
  assign push     = pipe_valid[ADD_LATENCY-1] & (cap_rd != 5'd0);
  assign wb_valid = (wb_count != '0);
  assign pop      = wb_valid & wb_ready;

  // Head is read straight out of the registered storage array.
  assign wb_rd   = mem_rd[rd_ptr];
  assign wb_data = mem_data[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) begin
        pipe_rd[i] <= '0;
      end
      // NOTE: the storage array is reset because the head is visible on
      // wb_rd/wb_data and those must read zero out of reset; with DEPTH this
      // small it costs only a reset term per flop.
      for (int i = 0; i < DEPTH; i++) begin
        mem_rd[i]   <= '0;
        mem_data[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_count <= '0;
      drop_err <= 1'b0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_rd[0]    <= uop_rd;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rd[i]    <= pipe_rd[i-1];
      end

      // At full with a concurrent pop, wr_ptr == rd_ptr; the head has
      // already been consumed this cycle, so overwriting it is safe.
      if (push) begin
        mem_rd[wr_ptr]   <= cap_rd;
        mem_data[wr_ptr] <= add_value;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   wb_count <= wb_count + CW'(1);
        2'b01:   wb_count <= wb_count - CW'(1);
        default: wb_count <= wb_count;
      endcase

      if (uop_valid_in && issue_stall) begin
        drop_err <= 1'b1;
      end
    end
  end

`ifdef INT_WB_FWD_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
    end else begin
      fwd_valid <= push;
      if (push) begin
        fwd_rd   <= cap_rd;
        fwd_data <= add_value;
      end
    end
  end
`endif

  // The credit rule must make a push into a full FIFO without a pop impossible.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (wb_count == CW'(DEPTH))));

endmodule

// File: tb/tb_int_add_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_int_add_wb_stage
//
// Self-checking bench for int_add_wb_stage (DEPTH=4, ADD_LATENCY=1).
// A hand-computed vector table covers the single add and the backpressure /
// full / drain case; directed sequences and randomized traffic are compared
// against a queue-based reference model of the writeback rules.
// -----------------------------------------------------------------------------
module tb_int_add_wb_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic          clk;
  logic          reset;
  logic          uop_valid_in;
  logic [4:0]    uop_rd;
  logic [DW-1:0] add_value;
  logic          issue_stall;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic [2:0]    wb_count;
  logic          drop_err;
`ifdef INT_WB_FWD_EN
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  int_add_wb_stage #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADD_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uop_valid_in(uop_valid_in),
    .uop_rd      (uop_rd),
    .add_value   (add_value),
    .issue_stall (issue_stall),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_count    (wb_count),
`ifdef INT_WB_FWD_EN
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
`endif
    .drop_err    (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; logic [DW-1:0] data; } res_t;
  typedef struct { logic [4:0] rd; int due; } tag_t;

  res_t m_q[$];
  tag_t m_fl[$];
  bit   m_drop = 1'b0;
  int   cyc    = 0;

  function automatic bit m_stall();
    return (m_q.size() + m_fl.size()) >= DEPTH;
  endfunction

  // Applies one clock edge worth of the writeback rules to the model.
  task automatic model_edge(input bit rst, input bit v, input logic [4:0] rd,
                            input logic [DW-1:0] val, input bit rdy);
    bit stall;
    tag_t t;
    cyc++;
    if (rst) begin
      m_q.delete();
      m_fl.delete();
      m_drop = 1'b0;
      return;
    end
    stall = m_stall();
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    while (m_fl.size() != 0 && m_fl[0].due == cyc) begin
      t = m_fl.pop_front();
      if (t.rd != 5'd0) m_q.push_back('{rd: t.rd, data: val});
    end
    if (v && !stall) m_fl.push_back('{rd: rd, due: cyc + LAT});
    if (v && stall) m_drop = 1'b1;
  endtask

  task automatic mcheck();
    check("wb_valid", 64'(wb_valid), 64'(m_q.size() != 0));
    check("wb_count", 64'(wb_count), 64'(m_q.size()));
    check("issue_stall", 64'(issue_stall), 64'(m_stall()));
    check("drop_err", 64'(drop_err), 64'(m_drop));
    if (m_q.size() != 0) begin
      check("wb_rd", 64'(wb_rd), 64'(m_q[0].rd));
      check("wb_data", 64'(wb_data), 64'(m_q[0].data));
    end
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, then
  // sample outputs 1 time unit after the edge.
  task automatic step(input bit rst, input bit v, input logic [4:0] rd,
                      input logic [DW-1:0] val, input bit rdy);
    reset = rst; uop_valid_in = v; uop_rd = rd; add_value = val; wb_ready = rdy;
    @(posedge clk);
    model_edge(rst, v, rd, val, rdy);
    #1;
  endtask

  task automatic mstep(input bit rst, input bit v, input logic [4:0] rd,
                       input logic [DW-1:0] val, input bit rdy);
    step(rst, v, rd, val, rdy);
    mcheck();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            v;
    logic [4:0]    rd;
    logic [DW-1:0] val;
    bit            rdy;
    bit            e_valid;
    logic [4:0]    e_rd;
    logic [DW-1:0] e_data;
    logic [2:0]    e_count;
    bit            e_stall;
  } vec_t;

  vec_t tbl[13];
  logic [DW-1:0] seen[$];

  initial begin
    // Single add: issue rd=5, data 0xA one edge later, visible for one cycle.
    tbl[0]  = '{1, 5'd5, 32'h0,     1, 0, 5'd0, 32'h0,     3'd0, 0};
    tbl[1]  = '{0, 5'd0, 32'hA,     1, 1, 5'd5, 32'hA,     3'd1, 0};
    tbl[2]  = '{0, 5'd0, 32'h0,     1, 0, 5'd0, 32'h0,     3'd0, 0};
    // Backpressure: four issues with wb_ready low fill every credit.
    tbl[3]  = '{1, 5'd1, 32'h0,     0, 0, 5'd0, 32'h0,     3'd0, 0};
    tbl[4]  = '{1, 5'd2, 32'h101,   0, 1, 5'd1, 32'h101,   3'd1, 0};
    tbl[5]  = '{1, 5'd3, 32'h102,   0, 1, 5'd1, 32'h101,   3'd2, 0};
    tbl[6]  = '{1, 5'd4, 32'h103,   0, 1, 5'd1, 32'h101,   3'd3, 1};
    tbl[7]  = '{0, 5'd0, 32'h104,   0, 1, 5'd1, 32'h101,   3'd4, 1};
    tbl[8]  = '{0, 5'd0, 32'h0,     0, 1, 5'd1, 32'h101,   3'd4, 1};
    // Drain in issue order, one per cycle.
    tbl[9]  = '{0, 5'd0, 32'h0,     1, 1, 5'd2, 32'h102,   3'd3, 0};
    tbl[10] = '{0, 5'd0, 32'h0,     1, 1, 5'd3, 32'h103,   3'd2, 0};
    tbl[11] = '{0, 5'd0, 32'h0,     1, 1, 5'd4, 32'h104,   3'd1, 0};
    tbl[12] = '{0, 5'd0, 32'h0,     1, 0, 5'd0, 32'h0,     3'd0, 0};

    // ---- reset state ----
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 0);
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_wb_count", 64'(wb_count), 64'(0));
    check("rst_issue_stall", 64'(issue_stall), 64'(0));
    check("rst_drop_err", 64'(drop_err), 64'(0));
    check("rst_wb_rd", 64'(wb_rd), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));

    // ---- table ----
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].v, tbl[i].rd, tbl[i].val, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), 64'(wb_valid), 64'(tbl[i].e_valid));
      check($sformatf("tbl%0d_count", i), 64'(wb_count), 64'(tbl[i].e_count));
      check($sformatf("tbl%0d_stall", i), 64'(issue_stall), 64'(tbl[i].e_stall));
      check($sformatf("tbl%0d_drop", i), 64'(drop_err), 64'(0));
      if (tbl[i].e_valid) begin
        check($sformatf("tbl%0d_rd", i), 64'(wb_rd), 64'(tbl[i].e_rd));
        check($sformatf("tbl%0d_data", i), 64'(wb_data), 64'(tbl[i].e_data));
      end
    end

    // ---- x0 result is discarded ----
    mstep(0, 1, 5'd0, 32'h0, 1);
    mstep(0, 0, 5'd0, 32'hDEAD_BEEF, 1);
    check("x0_no_valid", 64'(wb_valid), 64'(0));
    check("x0_no_drop", 64'(drop_err), 64'(0));
    mstep(0, 0, 5'd0, 32'h0, 1);

    // ---- simultaneous push/pop at count 3 with one in flight ----
    mstep(0, 1, 5'd1, 32'h0,  0);
    mstep(0, 1, 5'd2, 32'h10, 0);
    mstep(0, 1, 5'd3, 32'h11, 0);
    mstep(0, 1, 5'd4, 32'h12, 0);
    check("pre_full_count", 64'(wb_count), 64'(3));
    mstep(0, 0, 5'd0, 32'h13, 1);
    check("pushpop_count", 64'(wb_count), 64'(3));
    for (int i = 0; i < 4; i++) mstep(0, 0, 5'd0, 32'h0, 1);

    // ---- pointer wrap: 8 results, data 0..7, back to back ----
    seen.delete();
    for (int k = 0; k < 11; k++) begin
      mstep(0, k < 8, 5'((k % 31) + 1), DW'(k - 1), 1);
      if (wb_valid) seen.push_back(wb_data);
    end
    check("wrap_len", 64'(seen.size()), 64'(8));
    for (int k = 0; k < 8 && k < seen.size(); k++)
      check($sformatf("wrap_order%0d", k), 64'(seen[k]), 64'(k));

    // ---- stall violation ----
    mstep(0, 1, 5'd11, 32'h0,  0);
    mstep(0, 1, 5'd12, 32'h20, 0);
    mstep(0, 1, 5'd13, 32'h21, 0);
    mstep(0, 1, 5'd14, 32'h22, 0);
    check("viol_stall", 64'(issue_stall), 64'(1));
    mstep(0, 1, 5'd9, 32'h23, 0);
    check("viol_drop_err", 64'(drop_err), 64'(1));
    for (int i = 0; i < 6; i++) begin
      mstep(0, 0, 5'd0, 32'h99, 1);
      if (wb_valid) check("viol_not_rd9", 64'(wb_rd == 5'd9), 64'(0));
    end
    check("viol_drop_sticky", 64'(drop_err), 64'(1));

    // ---- reset mid-flight: 2 queued, 1 in flight ----
    mstep(0, 1, 5'd21, 32'h0,   0);
    mstep(0, 1, 5'd22, 32'h210, 0);
    mstep(0, 1, 5'd23, 32'h220, 0);
    check("mid_count", 64'(wb_count), 64'(2));
    step(1, 0, 5'd0, 32'h230, 1);
    check("mid_rst_valid", 64'(wb_valid), 64'(0));
    check("mid_rst_count", 64'(wb_count), 64'(0));
    check("mid_rst_stall", 64'(issue_stall), 64'(0));
    check("mid_rst_drop", 64'(drop_err), 64'(0));
    check("mid_rst_rd", 64'(wb_rd), 64'(0));
    check("mid_rst_data", 64'(wb_data), 64'(0));
    for (int i = 0; i < 4; i++) mstep(0, 0, 5'd0, 32'h230, 1);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      bit rst, v, rdy;
      rst = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 9) < 7);
      if (m_stall() && $urandom_range(0, 19) != 0) v = 1'b0;
      rdy = ($urandom_range(0, 9) < 6);
      mstep(rst, v, 5'($urandom_range(0, 31)), DW'($urandom), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
